// File: rtl/dpc_pkg.sv
// Shared limits, border-mode codes and tap slicing helper for the DPC pipeline.
package dpc_pkg;

  localparam int unsigned DPC_MAX_WIDTH = 32;
  localparam int unsigned DPC_MAX_DEPTH = 1024;

  localparam int unsigned BORDER_ZERO = 0;
  localparam int unsigned BORDER_REPL = 1;

  // LSB position of tap k inside a packed NUM_TAPS*width tap bus.
  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/dpc_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with 1-cycle synchronous read.
// A read and write to the same address in the same cycle returns the old contents.
module dpc_sdp_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write and registered read share one clocked process so inference stays simple.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/linebuf_multi_dpc.sv
// Multi-line delay buffer: presents NUM_TAPS vertically aligned pixels per accepted input.
// Stage 1 reads the line memories and registers the input; stage 2 writes the cascade and
// registers the border-filled tap bus.
module linebuf_multi_dpc
  import dpc_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_TAPS    = 3,
  parameter int unsigned MAX_DEPTH   = 1024,
  parameter int unsigned BORDER_MODE = BORDER_ZERO,
  parameter int unsigned AW          = $clog2(MAX_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AW-1:0]             cfg_line_len,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      out_valid,
  output logic [NUM_TAPS*WIDTH-1:0] out_taps,
  output logic [AW-2:0]             out_col,
  output logic [NUM_TAPS-1:0]       tap_valid
);

  localparam int unsigned CW = AW - 1;
  localparam int unsigned NM = NUM_TAPS - 1;
  localparam int unsigned RW = $clog2(NUM_TAPS);

  // Elaboration-time parameter checks.
  if (WIDTH < 1 || WIDTH > DPC_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "linebuf_multi_dpc: WIDTH out of range 1..32");
  end
  if (NUM_TAPS < 2 || NUM_TAPS > 8) begin : g_bad_taps
    $fatal(1, "linebuf_multi_dpc: NUM_TAPS out of range 2..8");
  end
  if (MAX_DEPTH < 2 || MAX_DEPTH > DPC_MAX_DEPTH || (MAX_DEPTH & (MAX_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $fatal(1, "linebuf_multi_dpc: MAX_DEPTH must be a power of two in 2..1024");
  end
  if (BORDER_MODE != BORDER_ZERO && BORDER_MODE != BORDER_REPL) begin : g_bad_border
    $fatal(1, "linebuf_multi_dpc: BORDER_MODE must be 0 or 1");
  end
  if (AW != $clog2(MAX_DEPTH) + 1) begin : g_bad_aw
    $fatal(1, "linebuf_multi_dpc: AW must equal clog2(MAX_DEPTH)+1");
  end

  logic [AW-1:0]    r_len;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_rows;
  logic             r_v1;
  logic [WIDTH-1:0] r_d1;
  logic [CW-1:0]    r_c1;
  logic [RW-1:0]    r_rows1;

  logic [AW-1:0]    w_len_cfg;
  logic [AW-1:0]    w_len_eff;
  logic [CW-1:0]    w_col_cur;
  logic [CW-1:0]    w_col_nxt;
  logic [RW-1:0]    w_rows_cur;
  logic [RW-1:0]    w_rows_nxt;
  logic             w_wrap;

  logic [WIDTH-1:0]          w_rd  [NM];
  logic [WIDTH-1:0]          w_raw [NUM_TAPS];
  logic [NUM_TAPS*WIDTH-1:0] w_taps;
  logic [NUM_TAPS-1:0]       w_tv;

  // Column/row position of the pixel being accepted; an SOF restarts at column 0, row 0.
  always_comb begin
    if (cfg_line_len < AW'(2)) begin
      w_len_cfg = AW'(2);
    end else if (cfg_line_len > AW'(MAX_DEPTH)) begin
      w_len_cfg = AW'(MAX_DEPTH);
    end else begin
      w_len_cfg = cfg_line_len;
    end
    w_len_eff  = in_sof ? w_len_cfg : r_len;
    w_col_cur  = in_sof ? '0 : r_col;
    w_rows_cur = in_sof ? '0 : r_rows;
    w_wrap     = ({1'b0, w_col_cur} == (w_len_eff - AW'(1)));
    w_col_nxt  = w_wrap ? '0 : w_col_cur + CW'(1);
    w_rows_nxt = (w_wrap && (w_rows_cur != RW'(NUM_TAPS - 1))) ? w_rows_cur + RW'(1)
                                                               : w_rows_cur;
  end

  // Frame position state; advances only on accepted pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len  <= AW'(MAX_DEPTH);
      r_col  <= '0;
      r_rows <= '0;
    end else if (in_valid) begin
      r_len  <= w_len_eff;
      r_col  <= w_col_nxt;
      r_rows <= w_rows_nxt;
    end
  end

  // Stage 1 registers: input pixel and its position, in step with the RAM read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_d1    <= '0;
      r_c1    <= '0;
      r_rows1 <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_d1    <= data_in;
        r_c1    <= w_col_cur;
        r_rows1 <= w_rows_cur;
      end
    end
  end

  // Line memory cascade: memory m is refilled with what memory m-1 held at this column.
  for (genvar m = 0; m < NM; m++) begin : g_mem
    logic [WIDTH-1:0] w_wdata;
    if (m == 0) begin : g_head
      assign w_wdata = r_d1;
    end else begin : g_chain
      assign w_wdata = w_rd[m-1];
    end
    dpc_sdp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_DEPTH)
    ) u_ram (
      .i_clk   (clk),
      .i_we    (r_v1),
      .i_waddr (r_c1),
      .i_wdata (w_wdata),
      .i_re    (in_valid),
      .i_raddr (w_col_cur),
      .o_rdata (w_rd[m])
    );
  end

  // Per-tap validity and border fill from the row count the pixel was accepted with.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int unsigned Lsb = tap_lsb(k, WIDTH);
    logic [WIDTH-1:0] w_tap;
    if (k == 0) begin : g_cur
      assign w_raw[k] = r_d1;
      assign w_tv[k]  = 1'b1;
    end else begin : g_old
      assign w_raw[k] = w_rd[k-1];
      assign w_tv[k]  = (RW'(k) <= r_rows1);
    end
    always_comb begin
      w_tap = '0;
      if (w_tv[k]) begin
        w_tap = w_raw[k];
      end else if (BORDER_MODE == BORDER_REPL) begin
        w_tap = w_raw[r_rows1];
      end
    end
    assign w_taps[Lsb +: WIDTH] = w_tap;
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_taps  <= '0;
      out_col   <= '0;
      tap_valid <= '0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        out_taps  <= w_taps;
        out_col   <= r_c1;
        tap_valid <= w_tv;
      end
    end
  end

endmodule
